operand_stage: RTL

//  Issue/operand-fetch stage between decode and execute. Drives the regfile read addresses from the

---
 rtl/operand_stage_pkg.sv | 32 +++
 rtl/operand_stage_bypass_mux.sv | 56 +++++
 rtl/operand_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/operand_stage_pkg.sv
// Shared types for the operand-fetch stage: machine word, register address,
// bypass source selector and the registered operand bundle handed to execute.
package operand_stage_pkg;

   localparam int XLEN      = 64;
   localparam int CTL_W_MAX = 32;

   typedef logic [XLEN-1:0] word_t;
   typedef logic [4:0]      creg_addr_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_EX  = 2'd3
   } fwd_src_t;

   // The ctl field is sized for the widest bundle; narrower bundles use the low bits.
   typedef struct packed {
      word_t                 pc;
      logic [CTL_W_MAX-1:0]  ctl;
      creg_addr_t            rd;
      word_t                 src1;
      word_t                 src2;
   } operand_out_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/operand_stage_bypass_mux.sv
// Resolves one source operand: picks EX, MEM, WB or regfile data (in that
// priority), forces x0 to zero, and flags a load-use dependency that must stall.
module bypass_mux
   import operand_stage_pkg::*;
(
   input  creg_addr_t addr,
   input  word_t      rf_data,
   input  logic       ex_we,
   input  creg_addr_t ex_rd,
   input  word_t      ex_data,
   input  logic       ex_is_load,
   input  logic       mem_we,
   input  creg_addr_t mem_rd,
   input  word_t      mem_data,
   input  logic       mem_busy,
   input  logic       wb_we,
   input  creg_addr_t wb_wa,
   input  word_t      wb_wd,
   output word_t      data,
   output logic       stall,
   output fwd_src_t   src
);

   logic nonzero;
   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   // Match each producing stage against the source and select the youngest producer.
   always_comb begin
      nonzero = (addr != 5'd0);
      ex_hit  = nonzero & ex_we  & (ex_rd  == addr);
      mem_hit = nonzero & mem_we & (mem_rd == addr);
      wb_hit  = nonzero & wb_we  & (wb_wa  == addr);
      stall   = (ex_hit & ex_is_load) | (mem_hit & mem_busy);
      data    = '0;
      src     = FWD_RF;
      if (!nonzero) begin
         data = '0;
         src  = FWD_RF;
      end else if (ex_hit) begin
         data = ex_data;
         src  = FWD_EX;
      end else if (mem_hit) begin
         data = mem_data;
         src  = FWD_MEM;
      end else if (wb_hit) begin
         data = wb_wd;
         src  = FWD_WB;
      end else begin
         data = rf_data;
         src  = FWD_RF;
      end
   end

endmodule

// File: rtl/operand_stage.sv
// Issue/operand-fetch stage: reads the regfile, merges EX/MEM/WB bypasses,
// stalls on load-use hazards and holds operands in a one-entry valid/ready
// register feeding execute. Optional macro OPERAND_STAGE_PERF_EN adds
// saturating stall-cycle and forwarding-hit counters.
module operand_stage
   import operand_stage_pkg::*;
#(
   parameter int CTL_W = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  word_t            in_pc,
   input  logic [CTL_W-1:0] in_ctl,
   input  creg_addr_t       in_rs1,
   input  creg_addr_t       in_rs2,
   input  creg_addr_t       in_rd,
   output creg_addr_t       rf_ra1,
   output creg_addr_t       rf_ra2,
   input  word_t            rf_rd1,
   input  word_t            rf_rd2,
   input  logic             ex_we,
   input  creg_addr_t       ex_rd,
   input  word_t            ex_data,
   input  logic             ex_is_load,
   input  logic             mem_we,
   input  creg_addr_t       mem_rd,
   input  word_t            mem_data,
   input  logic             mem_busy,
   input  logic             wb_we,
   input  creg_addr_t       wb_wa,
   input  word_t            wb_wd,
   output logic             out_valid,
   input  logic             out_ready,
   output word_t            out_pc,
   output logic [CTL_W-1:0] out_ctl,
   output creg_addr_t       out_rd,
   output word_t            out_src1,
   output word_t            out_src2
`ifdef OPERAND_STAGE_PERF_EN
   ,
   output logic [31:0]      perf_stall_cycles,
   output logic [31:0]      perf_fwd_hits
`endif
);

   word_t        src1_data;
   word_t        src2_data;
   logic         src1_stall;
   logic         src2_stall;
   fwd_src_t     src1_sel;
   fwd_src_t     src2_sel;
   logic         hazard;
   logic         accept;
   operand_out_t stage_d;
   operand_out_t stage_q;

   assign rf_ra1 = in_rs1;
   assign rf_ra2 = in_rs2;

   bypass_mux u_mux1 (
      .addr       (in_rs1),
      .rf_data    (rf_rd1),
      .ex_we      (ex_we),
      .ex_rd      (ex_rd),
      .ex_data    (ex_data),
      .ex_is_load (ex_is_load),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .mem_busy   (mem_busy),
      .wb_we      (wb_we),
      .wb_wa      (wb_wa),
      .wb_wd      (wb_wd),
      .data       (src1_data),
      .stall      (src1_stall),
      .src        (src1_sel)
   );

   bypass_mux u_mux2 (
      .addr       (in_rs2),
      .rf_data    (rf_rd2),
      .ex_we      (ex_we),
      .ex_rd      (ex_rd),
      .ex_data    (ex_data),
      .ex_is_load (ex_is_load),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .mem_busy   (mem_busy),
      .wb_we      (wb_we),
      .wb_wa      (wb_wa),
      .wb_wd      (wb_wd),
      .data       (src2_data),
      .stall      (src2_stall),
      .src        (src2_sel)
   );

   // Handshake: flush and load-use hazards block acceptance; otherwise accept when the register drains.
   always_comb begin
      hazard   = in_valid & (src1_stall | src2_stall);
      in_ready = !flush & !hazard & (!out_valid | out_ready);
      accept   = in_valid & in_ready;
   end

   // Assemble the bundle that will be captured on accept.
   always_comb begin
      stage_d                  = '0;
      stage_d.pc               = in_pc;
      stage_d.ctl[CTL_W-1:0]   = in_ctl;
      stage_d.rd               = in_rd;
      stage_d.src1             = src1_data;
      stage_d.src2             = src2_data;
   end

   // Pipeline register: flush squashes, accept loads, a consumed entry drains, otherwise hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         stage_q   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         stage_q   <= stage_d;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_pc   = stage_q.pc;
   assign out_ctl  = stage_q.ctl[CTL_W-1:0];
   assign out_rd   = stage_q.rd;
   assign out_src1 = stage_q.src1;
   assign out_src2 = stage_q.src2;

`ifdef OPERAND_STAGE_PERF_EN
   logic fwd_used;

   assign fwd_used = (src1_sel != FWD_RF) | (src2_sel != FWD_RF);

   // Saturating counters of hazard cycles and of accepted instructions that took a bypass.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_cycles <= '0;
         perf_fwd_hits     <= '0;
      end else begin
         if (hazard) begin
            perf_stall_cycles <= sat_inc(perf_stall_cycles);
         end
         if (accept && fwd_used) begin
            perf_fwd_hits <= sat_inc(perf_fwd_hits);
         end
      end
   end
`else
   logic [3:0] unused_fwd_sel;

   assign unused_fwd_sel = {src1_sel, src2_sel};
`endif

endmodule
